// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - framed, checksummed byte-stream loader for the MCU program memory
// Define LOADER_VERIFY_EN to add a read-back compare cycle after every word write.
module prog_mem_loader #(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 17,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  input  logic [DATA_W-1:0] pm_rdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_HI, S_MID, S_LO, S_WR, S_VFY, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  n_q;
  logic [7:0]  sum;
  logic [7:0]  mid_q;
  logic        hi_q;
  logic [8:0]  words;
  logic [31:0] tmo_cnt;
  logic        xfer, is_sync, wait_state, last_word, tmo_fire, commit;

  assign in_ready   = (state != S_WR) && (state != S_VFY);
  assign xfer       = in_valid && in_ready;
  assign is_sync    = xfer && (in_data == SYNC_BYTE);
  assign pm_we      = (state == S_WR);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign cpu_rst_n  = (state == S_DONE);
  assign wait_state = state inside {S_COUNT, S_HI, S_MID, S_LO, S_CSUM};
  // N == 0 encodes a full 256-word image, hence the 9-bit target.
  assign last_word  = (words + 9'd1) == {(n_q == 8'd0), n_q};
  assign tmo_fire   = (TIMEOUT_CYC != 0) && wait_state && !xfer &&
                      (tmo_cnt == 32'(TIMEOUT_CYC - 1));

`ifdef LOADER_VERIFY_EN
  assign commit = (state == S_VFY);
`else
  assign commit = (state == S_WR);
  logic rdata_unused;
  assign rdata_unused = ^pm_rdata;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (is_sync) state_next = S_COUNT;
      S_COUNT: if (xfer) state_next = S_HI;
      S_HI:    if (xfer) state_next = (in_data[7:1] != 7'd0) ? S_ERR : S_MID;
      S_MID:   if (xfer) state_next = S_LO;
      S_LO:    if (xfer) state_next = S_WR;
`ifdef LOADER_VERIFY_EN
      S_WR:    state_next = S_VFY;
      S_VFY:   state_next = (pm_rdata != pm_wdata) ? S_ERR : (last_word ? S_CSUM : S_HI);
`else
      S_WR:    state_next = last_word ? S_CSUM : S_HI;
`endif
      S_CSUM:  if (xfer) state_next = (8'(sum + in_data) == 8'd0) ? S_DONE : S_ERR;
      default: state_next = S_IDLE;
    endcase
    if (tmo_fire) state_next = S_ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q      <= '0;
      sum      <= '0;
      mid_q    <= '0;
      hi_q     <= 1'b0;
      words    <= '0;
      tmo_cnt  <= '0;
      pm_addr  <= '0;
      pm_wdata <= '0;
    end else begin
      if (wait_state && !xfer) tmo_cnt <= tmo_cnt + 32'd1;
      else                     tmo_cnt <= '0;
      if (commit) begin
        pm_addr <= pm_addr + ADDR_W'(1);
        words   <= words + 9'd1;
      end
      if (xfer) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (in_data == SYNC_BYTE) begin
              sum     <= '0;
              pm_addr <= '0;
              words   <= '0;
            end
          end
          S_COUNT: begin
            n_q <= in_data;
            sum <= sum + in_data;
          end
          S_HI: begin
            hi_q <= in_data[0];
            sum  <= sum + in_data;
          end
          S_MID: begin
            mid_q <= in_data;
            sum   <= sum + in_data;
          end
          S_LO: begin
            pm_wdata <= DATA_W'({hi_q, mid_q, in_data});
            sum      <= sum + in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - scoreboard bench for prog_mem_loader with a frame-level reference model
module tb_prog_mem_loader;

  localparam int TMO    = 40;
  localparam int R_DONE = 0;
  localparam int R_ERR  = 1;
  localparam int R_INC  = 2;
`ifdef LOADER_VERIFY_EN
  localparam int BUBBLE = 2;
`else
  localparam int BUBBLE = 1;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, pm_we, cpu_rst_n, done, error;
  logic [7:0]  pm_addr;
  logic [16:0] pm_wdata, pm_rdata;
  logic [16:0] mem [256];
  logic        rdata_zero = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  always #5 clk = ~clk;

  prog_mem_loader #(.ADDR_W(8), .DATA_W(17), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_rdata(pm_rdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  assign pm_rdata = rdata_zero ? 17'd0 : mem[pm_addr];
  always @(posedge clk) if (pm_we) mem[pm_addr] <= pm_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (pm_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", pm_addr, pm_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(pm_addr), 32'(mon_e[24:17]));
        check("wr_data", 32'(pm_wdata), 32'(mon_e[16:0]));
      end
    end
  end

  // Reference: parse a frame by the framing rules, queue expected writes, return the outcome.
  function automatic int model_frame(input bq_t f, output int nwr);
    int n, s, k;
    nwr = 0;
    n = (f[1] == 8'd0) ? 256 : int'(f[1]);
    s = int'(f[1]);
    for (int i = 0; i < n; i++) begin
      k = 2 + 3 * i;
      if (k >= f.size()) return R_INC;
      if (f[k] > 8'd1) return R_ERR;
      if (k + 2 >= f.size()) return R_INC;
      exp_q.push_back({8'(i), f[k][0], f[k+1], f[k+2]});
      nwr++;
      s = s + int'(f[k]) + int'(f[k+1]) + int'(f[k+2]);
    end
    if (2 + 3 * n >= f.size()) return R_INC;
    return ((s + int'(f[2 + 3 * n])) % 256 == 0) ? R_DONE : R_ERR;
  endfunction

  function automatic bq_t build_frame(input int n, input int bad_hi_at, input int csum_delta);
    bq_t f;
    int s;
    logic [7:0] hi, mid, lo;
    f.push_back(8'hA5);
    f.push_back(8'(n));
    s = n;
    for (int i = 0; i < ((n == 0) ? 256 : n); i++) begin
      hi  = (i == bad_hi_at) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      mid = 8'($urandom);
      lo  = 8'($urandom);
      f.push_back(hi);
      if (i == bad_hi_at) return f;
      f.push_back(mid);
      f.push_back(lo);
      s = s + int'(hi) + int'(mid) + int'(lo);
    end
    f.push_back(8'(256 - (s % 256) + csum_delta));
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      stall_cnt++;
      guard++;
      if (guard > 8) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_stuck: got 0 for %0d cycles, required 1", guard);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_junk(input int cnt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send_byte(b);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bq_t f, input int max_gap, output int res);
    int nwr, st0;
    bit gapless;
    res = model_frame(f, nwr);
    st0 = stall_cnt;
    gapless = 1'b1;
    foreach (f[i]) begin
      send_byte(f[i]);
      if (max_gap > 0 && $urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, max_gap));
        gapless = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (res != R_INC) begin
      check("done", 32'(done), 32'(res == R_DONE));
      check("error", 32'(error), 32'(res == R_ERR));
      check("cpu_rst_n", 32'(cpu_rst_n), 32'(res == R_DONE));
    end
    if (gapless) check("stall_cycles", 32'(stall_cnt - st0), 32'(nwr * BUBBLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t f;
    int res, nwr, s;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pm_we", 32'(pm_we), 32'd0);
    check("rst_pm_addr", 32'(pm_addr), 32'd0);
    check("rst_pm_wdata", 32'(pm_wdata), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    f = {8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h96};
    run_frame(f, 0, res);
    send_junk(3);
    check("junk_keeps_done", 32'(done), 32'd1);

    f = {8'hA5, 8'h00};
    s = 0;
    for (int i = 0; i < 256; i++) begin
      f.push_back(8'(i % 2));
      f.push_back(8'(i));
      f.push_back(8'(i + 1));
      s = s + (i % 2) + (i % 256) + ((i + 1) % 256);
    end
    f.push_back(8'(256 - (s % 256)));
    run_frame(f, 0, res);
    check("full_image_addr_wrap", 32'(pm_addr), 32'd0);

    f = {8'hA5, 8'h01, 8'h02};
    run_frame(f, 0, res);
    run_frame(build_frame(2, -1, 0), 0, res);
    run_frame(build_frame(3, -1, 1), 0, res);

    for (int it = 0; it < 20; it++) begin
      int kind, n;
      n = $urandom_range(1, 6);
      kind = $urandom_range(0, 3);
      if (kind <= 1)      f = build_frame(n, -1, 0);
      else if (kind == 2) f = build_frame(n, -1, $urandom_range(1, 255));
      else                f = build_frame(n, $urandom_range(0, n - 1), 0);
      run_frame(f, $urandom_range(0, 1) * 6, res);
      if ($urandom_range(0, 1) == 1) begin
        send_junk($urandom_range(1, 3));
        check("junk_done", 32'(done), 32'(res == R_DONE));
        check("junk_error", 32'(error), 32'(res == R_ERR));
      end
    end

    f = {8'hA5, 8'h01, 8'h01, 8'h23};
    run_frame(f, 0, res);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet", 32'(error), 32'd0);
    @(negedge clk);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

    run_frame(build_frame(1, -1, 0), 0, res);
    f = {8'hA5, 8'h02, 8'h01, 8'h11};
    run_frame(f, 0, res);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(build_frame(2, -1, 0), 0, res);

`ifdef LOADER_VERIFY_EN
    rdata_zero = 1'b1;
    f = {8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h96};
    exp_q.push_back({8'h00, 17'h12345});
    foreach (f[i]) send_byte(f[i]);
    in_valid = 1'b0;
    check("vfy_error", 32'(error), 32'd1);
    check("vfy_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    rdata_zero = 1'b0;
`endif

    repeat (4) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
